// File: rtl/fsm_clock.sv
// fsm_clock: 24-hour time-of-day counter driven by a prescaled system clock.
// A tick every CLK_DIV cycles advances seconds/minutes/hours; the midnight
// rollover raises new_day for exactly one cycle.
module fsm_clock #(
    parameter int CLK_DIV = 1,
    parameter int CNT_W   = 26
) (
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] cnt_minute,
    output logic [6:0] cnt_second,
    output logic [4:0] hour,
    output logic       new_day
);

    // State records which carry chain fired on the last tick edge.
    typedef enum logic [1:0] {
        COUNT     = 2'd0,
        ROLL_MIN  = 2'd1,
        ROLL_HOUR = 2'd2,
        ROLL_DAY  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(CLK_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] prescaler;
    logic             tick;
    logic             sec_end;
    logic             min_end;
    logic             hour_end;

    assign tick = (prescaler == DIV_MAX);

    // Anything at or beyond the terminal value is treated as terminal, so a
    // corrupted counter still wraps to 0 on the next tick.
    assign sec_end  = (cnt_second >= 7'd59);
    assign min_end  = (cnt_minute >= 7'd59);
    assign hour_end = (hour >= 5'd23);

    // new_day is a decode of the registered state: it is high only in the
    // cycle right after the day-carry edge and clears with the async reset.
    assign new_day = (state == ROLL_DAY);

    // Prescaler: 0..CLK_DIV-1, wrapping on the tick cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    // Carry-select update of the time registers and rollover state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= COUNT;
            cnt_second <= '0;
            cnt_minute <= '0;
            hour       <= '0;
        end else begin
            state <= COUNT;
            if (tick) begin
                if (!sec_end) begin
                    cnt_second <= cnt_second + 7'd1;
                end else begin
                    cnt_second <= '0;
                    if (!min_end) begin
                        cnt_minute <= cnt_minute + 7'd1;
                        state      <= ROLL_MIN;
                    end else begin
                        cnt_minute <= '0;
                        if (!hour_end) begin
                            hour  <= hour + 5'd1;
                            state <= ROLL_HOUR;
                        end else begin
                            hour  <= '0;
                            state <= ROLL_DAY;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_clock.sv
// tb_fsm_clock: directed checks of the time-of-day counter. One CLK_DIV=1
// instance walks a full day against a vector table; companions cover the
// prescaled tick, async reset mid-day and async reset during new_day.
module tb_fsm_clock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_4 = 1'b1;

    logic [6:0] min_a, sec_a, min_b, sec_b, min_c, sec_c, min_4, sec_4;
    logic [4:0] hr_a, hr_b, hr_c, hr_4;
    logic       nd_a, nd_b, nd_c, nd_4;

    fsm_clock #(.CLK_DIV(1), .CNT_W(26)) dut_a (
        .clk(clk), .reset(rst_a), .cnt_minute(min_a), .cnt_second(sec_a),
        .hour(hr_a), .new_day(nd_a));
    fsm_clock #(.CLK_DIV(1), .CNT_W(26)) dut_b (
        .clk(clk), .reset(rst_b), .cnt_minute(min_b), .cnt_second(sec_b),
        .hour(hr_b), .new_day(nd_b));
    fsm_clock #(.CLK_DIV(1), .CNT_W(26)) dut_c (
        .clk(clk), .reset(rst_c), .cnt_minute(min_c), .cnt_second(sec_c),
        .hour(hr_c), .new_day(nd_c));
    fsm_clock #(.CLK_DIV(4), .CNT_W(4)) dut_4 (
        .clk(clk), .reset(rst_4), .cnt_minute(min_4), .cnt_second(sec_4),
        .hour(hr_4), .new_day(nd_4));

    typedef struct {
        int edge_n;   // edges since reset release
        int hh;
        int mm;
        int ss;
        int nd;
    } vec_t;

    vec_t vec[10];

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int nd_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic int hms(input logic [4:0] h, input logic [6:0] m, input logic [6:0] s);
        return int'(h) * 10000 + int'(m) * 100 + int'(s);
    endfunction

    // One rising edge, then sample 1 ns later; side checks keyed on edge count.
    task automatic step();
        @(posedge clk);
        edges++;
        #1;
        if (nd_a) nd_count++;
        // CLK_DIV=4: tick on every 4th edge, values hold in between
        if (edges <= 16) begin
            chk("div4_sec", int'(sec_4), edges / 4);
            chk("div4_nd", int'(nd_4), 0);
        end
        if (edges == 3600) chk("no_new_day_first_hour", nd_count, 0);
        // async reset between edges at 12:34:56
        if (edges == 45296) begin
            chk("b_at_123456", hms(hr_b, min_b, sec_b), 123456);
            #2 rst_b = 1'b0;
            #1 chk("b_async_clear", hms(hr_b, min_b, sec_b), 0);
            chk("b_async_nd", int'(nd_b), 0);
        end
        // async reset during the new_day cycle
        if (edges == 86400) begin
            chk("c_new_day_high", int'(nd_c), 1);
            #2 rst_c = 1'b0;
            #1 chk("c_new_day_cleared", int'(nd_c), 0);
            chk("c_time_zero", hms(hr_c, min_c, sec_c), 0);
        end
    endtask

    initial begin
        vec[0] = '{5,     0,  0,  5, 0};
        vec[1] = '{59,    0,  0, 59, 0};
        vec[2] = '{60,    0,  1,  0, 0};
        vec[3] = '{3599,  0, 59, 59, 0};
        vec[4] = '{3600,  1,  0,  0, 0};
        vec[5] = '{45296, 12, 34, 56, 0};
        vec[6] = '{86399, 23, 59, 59, 0};
        vec[7] = '{86400, 0,  0,  0, 1};
        vec[8] = '{86401, 0,  0,  1, 0};
        vec[9] = '{86405, 0,  0,  5, 0};

        // reset asserted for 100 ns with the clock running
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #20;
            chk("reset_time", hms(hr_a, min_a, sec_a), 0);
            chk("reset_new_day", int'(nd_a), 0);
        end
        chk("reset_div4", hms(hr_4, min_4, sec_4), 0);

        // release all instances together on a falling edge
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_4 = 1'b1;

        for (int v = 0; v < 10; v++) begin
            while (edges < vec[v].edge_n) step();
            chk($sformatf("time@%0d", vec[v].edge_n), hms(hr_a, min_a, sec_a),
                vec[v].hh * 10000 + vec[v].mm * 100 + vec[v].ss);
            chk($sformatf("new_day@%0d", vec[v].edge_n), int'(nd_a), vec[v].nd);
        end
        chk("new_day_pulse_count", nd_count, 1);
        chk("bit6_clear", int'(sec_a[6]) + int'(min_a[6]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
